// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants, mode type and width helper for the button conditioner
package btn_pkg;

  localparam int BTN_A   = 0;
  localparam int BTN_B   = 1;
  localparam int BTN_P   = 2;
  localparam int NUM_BTN = 3;

  localparam int DEF_TICK_DIV   = 50000;
  localparam int DEF_STABLE_CNT = 4;
  localparam int DEF_LONG_TICKS = 2000;

  // Stop modes are mutually exclusive, so they are encoded as one state rather than two flags
  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_STOPA = 2'd1,
    MODE_STOPB = 2'd2
  } stop_mode_t;

  // Bits needed to hold a counter value of 0..max_val
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchroniser, tick-sampled debouncer and rise detect
module btn_debounce
  import btn_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int SW = cnt_width(STABLE_CNT);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);

  logic          sync_meta;
  logic          sync_out;
  logic [SW-1:0] stable_cnt;
  logic          level_d;

  // Synchronise the raw input, then accept a new level only after it disagrees on STABLE_CNT consecutive ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta  <= 1'b0;
      sync_out   <= 1'b0;
      stable_cnt <= '0;
      level      <= 1'b0;
      level_d    <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
      level_d   <= level;
      if (tick) begin
        if (sync_out != level) begin
          if (stable_cnt == STABLE_LAST) begin
            level      <= ~level;
            stable_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end else begin
          stable_cnt <= '0;
        end
      end
    end
  end

  // High for the one cycle after the debounced level rises; the top registers it as the press pulse
  assign rise = level & ~level_d;

endmodule

// File: rtl/btn_condition.sv
// rtl/btn_condition.sv - button conditioner top: tick divider, debouncers, stop/pause mode logic (optional BTN_LONGPRESS_EN)
module btn_condition
  import btn_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int LONG_TICKS = DEF_LONG_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_stopa,
  input  logic       btn_stopb,
  input  logic       btn_pause,
  output logic       stopa,
  output logic       stopb,
  output logic       pause,
  output logic [2:0] press
);

  localparam int TW = cnt_width(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;
  logic               long_fire;
  logic               unused_level;
  stop_mode_t         mode;
  stop_mode_t         mode_next;
  logic               pause_next;

  // Free-running debounce sample divider
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  assign raw[BTN_A] = btn_stopa;
  assign raw[BTN_B] = btn_stopb;
  assign raw[BTN_P] = btn_pause;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .STABLE_CNT(STABLE_CNT)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .raw  (raw[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

`ifdef BTN_LONGPRESS_EN
  localparam int LW = cnt_width(LONG_TICKS);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS);

  logic [1:0] long_hit;

  for (genvar i = 0; i < 2; i++) begin : g_hold
    logic [LW-1:0] hold_cnt;
    logic          hold_seen;

    // Count ticks while the stop button stays down; hold_seen limits the forced release to once per hold
    always_ff @(posedge clk) begin
      if (rst || !level[i]) begin
        hold_cnt  <= '0;
        hold_seen <= 1'b0;
      end else begin
        if (tick && (hold_cnt != LONG_LAST)) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        hold_seen <= (hold_cnt == LONG_LAST);
      end
    end

    assign long_hit[i] = (hold_cnt == LONG_LAST) && !hold_seen;
  end

  assign long_fire = |long_hit;
`else
  // Without long-press support a held button is just one press
  localparam int unused_long_ticks = LONG_TICKS;
  assign long_fire = 1'b0;
`endif

  // Only the rise pulses drive the modes; the levels are consumed solely by the hold counters
  assign unused_level = ^level;

  // Mode, pause and press registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode  <= MODE_IDLE;
      pause <= 1'b0;
      press <= 3'b000;
    end else begin
      mode  <= mode_next;
      pause <= pause_next;
      press <= rise;
    end
  end

  // Next mode from this cycle's rise pulses; simultaneous A and B presses cancel out
  always_comb begin
    mode_next  = mode;
    pause_next = pause;
    if (long_fire) begin
      mode_next  = MODE_IDLE;
      pause_next = 1'b0;
    end else begin
      case ({rise[BTN_B], rise[BTN_A]})
        2'b01:   mode_next = (mode == MODE_STOPA) ? MODE_IDLE : MODE_STOPA;
        2'b10:   mode_next = (mode == MODE_STOPB) ? MODE_IDLE : MODE_STOPB;
        default: mode_next = mode;
      endcase
      if (rise[BTN_P]) begin
        pause_next = ~pause;
      end
    end
  end

  assign stopa = (mode == MODE_STOPA);
  assign stopb = (mode == MODE_STOPB);

endmodule
